// File: rtl/mux_nx1_tdm.sv
// mux_nx1_tdm
//   Registered N:1 channel multiplexer with valid/ready flow control.
//   The channel is chosen either by an explicit select (MANUAL) or by a
//   round-robin scan that dwells DWELL loading cycles on each channel (SCAN).
//   Selected data appears on dout exactly one cycle after it is accepted,
//   tagged with the index of the channel it came from.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   din         N packed channels, channel i at din[i*WIDTH +: WIDTH]
//   din_valid   per-channel valid
//   din_ready   per-channel ready, one-hot or zero (combinational)
//   mode        0 = MANUAL, 1 = SCAN
//   sel         MANUAL channel select; out-of-range values hold the last channel
//   dout        registered selected data
//   dout_valid  dout holds a valid word
//   dout_ch     channel index dout was taken from
//   out_ready   downstream accepts dout this cycle

module mux_nx1_tdm #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int DWELL = 4,
   localparam int SEL_W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*WIDTH-1:0]   din,
   input  logic [N-1:0]         din_valid,
   output logic [N-1:0]         din_ready,
   input  logic                 mode,
   input  logic [SEL_W-1:0]     sel,
   output logic [WIDTH-1:0]     dout,
   output logic                 dout_valid,
   output logic [SEL_W-1:0]     dout_ch,
   input  logic                 out_ready
);

   // A single-valued counter still needs one bit to exist.
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(N - 1);

   logic [SEL_W-1:0] cur;
   logic [CNT_W-1:0] dwell_cnt;
   logic             load;
   logic [SEL_W-1:0] eff_ch;
   logic [WIDTH-1:0] ch_data [N];

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign ch_data[i] = din[i*WIDTH +: WIDTH];
   end

   // Output register is free when empty or being drained this cycle.
   assign load = !dout_valid || out_ready;

   // An out-of-range manual select keeps whatever channel was last in use.
   always_comb begin
      eff_ch = cur;
      if (!mode && (int'(sel) < N)) begin
         eff_ch = sel;
      end
   end

   always_comb begin
      din_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (load && (eff_ch == SEL_W'(i))) begin
            din_ready[i] = 1'b1;
         end
      end
   end

   // ---- stage boundary: selected channel -> output register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_ch    <= '0;
      end else if (load) begin
         dout       <= ch_data[eff_ch];
         dout_valid <= din_valid[eff_ch];
         dout_ch    <= eff_ch;
      end
   end

   // Channel tracking. In MANUAL the counter sits at 0 so a later switch to
   // SCAN starts a fresh dwell from the last manual channel. In SCAN the
   // dwell only advances on loading cycles, so a stall never costs a channel
   // its slot, while idle channels still consume theirs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur       <= '0;
         dwell_cnt <= '0;
      end else if (!mode) begin
         cur       <= eff_ch;
         dwell_cnt <= '0;
      end else if (load) begin
         if (dwell_cnt == CNT_LAST) begin
            dwell_cnt <= '0;
            cur       <= (cur == CH_LAST) ? '0 : cur + SEL_W'(1);
         end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mux_nx1_tdm.sv
// tb_mux_nx1_tdm
//   Bench for mux_nx1_tdm with two instances: N=4/DWELL=2 and N=3/DWELL=3.
//   Directed table vectors, hand-written multi-cycle sequences and a
//   randomized run against a slot-counting reference model.

module tb_mux_nx1_tdm;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // N=4 instance
   logic [31:0] din4;
   logic [3:0]  vld4, rdy4;
   logic        mode4, ordy4, dv4;
   logic [1:0]  sel4, ch4;
   logic [7:0]  dout4;

   // N=3 instance
   logic [23:0] din3;
   logic [2:0]  vld3, rdy3;
   logic        mode3, ordy3, dv3;
   logic [1:0]  sel3, ch3;
   logic [7:0]  dout3;

   mux_nx1_tdm #(.N(4), .WIDTH(8), .DWELL(2)) dut4 (
      .clk(clk), .rst(rst), .din(din4), .din_valid(vld4), .din_ready(rdy4),
      .mode(mode4), .sel(sel4), .dout(dout4), .dout_valid(dv4),
      .dout_ch(ch4), .out_ready(ordy4));

   mux_nx1_tdm #(.N(3), .WIDTH(8), .DWELL(3)) dut3 (
      .clk(clk), .rst(rst), .din(din3), .din_valid(vld3), .din_ready(rdy3),
      .mode(mode3), .sel(sel3), .dout(dout3), .dout_valid(dv3),
      .dout_ch(ch3), .out_ready(ordy3));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: in SCAN the channel is the start channel plus the
   // number of loading cycles divided by the dwell, modulo N.
   typedef struct {
      int last_ch;
      int start;
      int loads;
      bit in_scan;
      bit dv;
      int dout;
      int ch;
   } mdl_t;

   mdl_t m4, m3;

   function automatic mdl_t m_reset();
      mdl_t r;
      r.last_ch = 0; r.start = 0; r.loads = 0; r.in_scan = 0;
      r.dv = 0; r.dout = 0; r.ch = 0;
      return r;
   endfunction

   function automatic int m_cur(mdl_t s, int n, int d);
      return s.in_scan ? (s.start + s.loads / d) % n : s.last_ch;
   endfunction

   function automatic int m_eff(mdl_t s, int n, int d, bit md, int sl);
      int c;
      c = m_cur(s, n, d);
      if (md) return c;
      return (sl < n) ? sl : c;
   endfunction

   function automatic mdl_t m_step(mdl_t s, int n, int d, bit md, int sl,
                                   logic [31:0] data, logic [3:0] vld, bit ordy);
      mdl_t r;
      int c, e;
      bit ld;
      r  = s;
      c  = m_cur(s, n, d);
      e  = m_eff(s, n, d, md, sl);
      ld = !s.dv || ordy;
      if (ld) begin
         r.dout = int'((data >> (8 * e)) & 32'hFF);
         r.ch   = e;
         r.dv   = vld[e];
      end
      if (md) begin
         if (!s.in_scan) begin
            r.in_scan = 1; r.start = c; r.loads = 0;
         end
         if (ld) r.loads = r.loads + 1;
      end else begin
         r.in_scan = 0;
         r.last_ch = e;
      end
      return r;
   endfunction

   // Inputs are already applied; check ready before the edge, outputs after.
   task automatic cyc4(input string nm, input logic [3:0] er, input logic [7:0] ed,
                       input logic [1:0] ec, input logic ev);
      #1;
      chk({nm, ".rdy"}, 32'(rdy4), 32'(er));
      @(posedge clk); #1;
      chk({nm, ".dout"}, 32'(dout4), 32'(ed));
      chk({nm, ".ch"},   32'(ch4),   32'(ec));
      chk({nm, ".dv"},   32'(dv4),   32'(ev));
   endtask

   task automatic cyc3(input string nm, input logic [2:0] er, input logic [7:0] ed,
                       input logic [1:0] ec, input logic ev);
      #1;
      chk({nm, ".rdy"}, 32'(rdy3), 32'(er));
      @(posedge clk); #1;
      chk({nm, ".dout"}, 32'(dout3), 32'(ed));
      chk({nm, ".ch"},   32'(ch3),   32'(ec));
      chk({nm, ".dv"},   32'(dv3),   32'(ev));
   endtask

   task automatic step4_model();
      int e;
      logic [3:0] er;
      mdl_t r;
      e  = m_eff(m4, 4, 2, mode4, int'(sel4));
      er = (!m4.dv || ordy4) ? 4'(1 << e) : 4'b0;
      r  = m_step(m4, 4, 2, mode4, int'(sel4), din4, vld4, ordy4);
      cyc4("rand4", er, 8'(r.dout), 2'(r.ch), r.dv);
      m4 = r;
   endtask

   task automatic step3_model();
      int e;
      logic [2:0] er;
      mdl_t r;
      e  = m_eff(m3, 3, 3, mode3, int'(sel3));
      er = (!m3.dv || ordy3) ? 3'(1 << e) : 3'b0;
      r  = m_step(m3, 3, 3, mode3, int'(sel3), {8'h00, din3}, {1'b0, vld3}, ordy3);
      cyc3("rand3", er, 8'(r.dout), 2'(r.ch), r.dv);
      m3 = r;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  vld;
      logic        ordy;
      logic [31:0] din;
      logic [3:0]  exp_rdy;
      logic [7:0]  exp_dout;
      logic [1:0]  exp_ch;
      logic        exp_dv;
   } vec_t;

   vec_t tbl[12];

   int   sc_ch[10]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
   bit   st_or[8]   = '{1, 1, 1, 0, 0, 0, 1, 1};
   int   st_ch[8]   = '{0, 0, 1, 1, 1, 1, 1, 2};
   int   st_rdy[8]  = '{1, 1, 2, 0, 0, 0, 2, 4};

   initial begin
      // MANUAL select sweep, then stall/hold, invalid word, load-while-empty
      tbl[0]  = '{1'b0, 2'd0, 4'hF,    1'b1, 32'hDDCCBBAA, 4'b0001, 8'hAA, 2'd0, 1'b1};
      tbl[1]  = '{1'b0, 2'd1, 4'hF,    1'b1, 32'hDDCCBBAA, 4'b0010, 8'hBB, 2'd1, 1'b1};
      tbl[2]  = '{1'b0, 2'd2, 4'hF,    1'b1, 32'hDDCCBBAA, 4'b0100, 8'hCC, 2'd2, 1'b1};
      tbl[3]  = '{1'b0, 2'd3, 4'hF,    1'b1, 32'hDDCCBBAA, 4'b1000, 8'hDD, 2'd3, 1'b1};
      tbl[4]  = '{1'b0, 2'd2, 4'hF,    1'b1, 32'hDDCCBBAA, 4'b0100, 8'hCC, 2'd2, 1'b1};
      tbl[5]  = '{1'b0, 2'd2, 4'hF,    1'b0, 32'h11223344, 4'b0000, 8'hCC, 2'd2, 1'b1};
      tbl[6]  = '{1'b0, 2'd2, 4'hF,    1'b0, 32'h11223344, 4'b0000, 8'hCC, 2'd2, 1'b1};
      tbl[7]  = '{1'b0, 2'd2, 4'hF,    1'b0, 32'h11223344, 4'b0000, 8'hCC, 2'd2, 1'b1};
      tbl[8]  = '{1'b0, 2'd2, 4'hF,    1'b1, 32'h11223344, 4'b0100, 8'h22, 2'd2, 1'b1};
      tbl[9]  = '{1'b0, 2'd2, 4'b1011, 1'b1, 32'h11223344, 4'b0100, 8'h22, 2'd2, 1'b0};
      tbl[10] = '{1'b0, 2'd1, 4'hF,    1'b0, 32'h11223344, 4'b0010, 8'h33, 2'd1, 1'b1};
      tbl[11] = '{1'b0, 2'd3, 4'hF,    1'b0, 32'h11223344, 4'b0000, 8'h33, 2'd1, 1'b1};

      din4 = '0; vld4 = '0; mode4 = 1'b0; sel4 = '0; ordy4 = 1'b0;
      din3 = '0; vld3 = '0; mode3 = 1'b0; sel3 = '0; ordy3 = 1'b0;
      rst = 1'b0;
      #1 rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst.dout", 32'(dout4), 32'h0);
      chk("rst.dv",   32'(dv4),   32'h0);
      chk("rst.ch",   32'(ch4),   32'h0);
      chk("rst.dv3",  32'(dv3),   32'h0);
      rst = 1'b0;

      for (int k = 0; k < 12; k++) begin
         mode4 = tbl[k].mode; sel4 = tbl[k].sel; vld4 = tbl[k].vld;
         ordy4 = tbl[k].ordy; din4 = tbl[k].din;
         cyc4($sformatf("tbl%0d", k), tbl[k].exp_rdy, tbl[k].exp_dout,
              tbl[k].exp_ch, tbl[k].exp_dv);
      end

      // SCAN round-robin with wrap
      do_reset();
      mode4 = 1'b1; vld4 = 4'hF; ordy4 = 1'b1; din4 = 32'hDDCCBBAA;
      for (int k = 0; k < 10; k++) begin
         cyc4($sformatf("scan%0d", k), 4'(1 << sc_ch[k]),
              8'hAA + 8'(sc_ch[k]) * 8'h11, 2'(sc_ch[k]), 1'b1);
      end

      // SCAN stall during channel 1 dwell: remaining slot survives the stall
      do_reset();
      for (int k = 0; k < 8; k++) begin
         ordy4 = st_or[k];
         cyc4($sformatf("stall%0d", k), 4'(st_rdy[k]),
              8'hAA + 8'(st_ch[k]) * 8'h11, 2'(st_ch[k]), 1'b1);
      end

      // Asynchronous reset mid-stream, then scan restarts at channel 0
      chk("prerst.dv", 32'(dv4), 32'h1);
      rst = 1'b1;
      #1;
      chk("midrst.dout", 32'(dout4), 32'h0);
      chk("midrst.dv",   32'(dv4),   32'h0);
      chk("midrst.ch",   32'(ch4),   32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      cyc4("postrst0", 4'b0001, 8'hAA, 2'd0, 1'b1);
      cyc4("postrst1", 4'b0001, 8'hAA, 2'd0, 1'b1);
      cyc4("postrst2", 4'b0010, 8'hBB, 2'd1, 1'b1);

      // N=3: out-of-range select holds the last channel
      do_reset();
      mode3 = 1'b0; vld3 = 3'b111; ordy3 = 1'b1; din3 = 24'h332211;
      sel3 = 2'd1;
      cyc3("oor_a", 3'b010, 8'h22, 2'd1, 1'b1);
      sel3 = 2'd3;
      cyc3("oor_b", 3'b010, 8'h22, 2'd1, 1'b1);
      cyc3("oor_c", 3'b010, 8'h22, 2'd1, 1'b1);

      // Randomized run, N=4
      do_reset();
      m4 = m_reset();
      mode4 = 1'b0;
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 15) == 0) mode4 = ~mode4;
         sel4  = 2'($urandom);
         vld4  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         ordy4 = ($urandom_range(0, 3) != 0);
         din4  = $urandom;
         step4_model();
      end

      // Randomized run, N=3 (sel=3 is out of range)
      do_reset();
      m3 = m_reset();
      mode3 = 1'b0;
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 15) == 0) mode3 = ~mode3;
         sel3  = 2'($urandom);
         vld3  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
         ordy3 = ($urandom_range(0, 3) != 0);
         din3  = 24'($urandom);
         step3_model();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
